// File: rtl/recv_module.sv
// Receive-side packet checker for one switch output port: parses the header, checks framing and counts packets.
// Optional payload content check is enabled by defining RECV_DATA_CHECK_EN.
module recv_module #(
    parameter int RX_PORT    = 0,
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH_SEL  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  ready,
    input  logic                  rd_sop,
    input  logic                  rd_eop,
    input  logic                  rd_vld,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  pkt_ok,
    output logic [2:0]            last_priority,
    output logic [9:0]            last_length,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DATA,
        DRAIN
    } state_t;

    localparam logic [WIDTH_SEL-1:0] PORT_SEL = WIDTH_SEL'(RX_PORT);

    state_t     state;
    state_t     next_state;
    logic [9:0] word_cnt;
    logic [9:0] word_next;
    logic [9:0] hdr_length;
    logic       hdr_err;
    logic       data_err;
    logic       close_pkt;
    logic       close_good;
    logic       capture;
    logic       count_word;
    logic       unused_bits;

    assign hdr_length  = rd_data[16:7];
    assign word_next   = word_cnt + 10'd1;
    assign hdr_err     = (rd_data[WIDTH_SEL-1:0] != PORT_SEL) || (hdr_length == 10'd0) || rd_eop;
    assign unused_bits = ^rd_data;

`ifdef RECV_DATA_CHECK_EN
    localparam logic [15:0] PORT_TAG = 16'(RX_PORT);
    assign data_err = (rd_data[31:0] != {PORT_TAG, 6'd0, word_cnt});
`else
    assign data_err = 1'b0;
`endif

    // A new rd_sop always wins: whatever packet is open gets closed as bad first.
    always_comb begin
        next_state = state;
        close_pkt  = 1'b0;
        close_good = 1'b0;
        capture    = 1'b0;
        count_word = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_sop) begin
                    next_state = HEAD;
                end
            end
            HEAD: begin
                if (rd_sop) begin
                    close_pkt  = 1'b1;
                    next_state = HEAD;
                end else if (rd_vld) begin
                    capture = 1'b1;
                    if (rd_eop) begin
                        close_pkt  = 1'b1;
                        next_state = IDLE;
                    end else if (hdr_err) begin
                        next_state = DRAIN;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (rd_sop) begin
                    close_pkt  = 1'b1;
                    next_state = HEAD;
                end else if (rd_vld) begin
                    count_word = 1'b1;
                    if (rd_eop) begin
                        close_pkt  = 1'b1;
                        close_good = (word_next == last_length) && !data_err;
                        next_state = IDLE;
                    end else if ((word_next == last_length) || data_err) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_sop) begin
                    close_pkt  = 1'b1;
                    next_state = HEAD;
                end else if (rd_vld && rd_eop) begin
                    close_pkt  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ready         <= 1'b0;
            done          <= 1'b0;
            pkt_ok        <= 1'b0;
            last_priority <= 3'd0;
            last_length   <= 10'd0;
            pkt_cnt       <= 16'd0;
            err_cnt       <= 16'd0;
            word_cnt      <= 10'd0;
        end else begin
            state <= next_state;
            ready <= en;
            done  <= close_pkt;
            if (close_pkt) begin
                pkt_ok <= close_good;
                if (close_good) begin
                    if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
                end else begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                end
            end
            if (capture) begin
                last_priority <= rd_data[6:4];
                last_length   <= hdr_length;
                word_cnt      <= 10'd0;
            end else if (count_word) begin
                word_cnt <= word_next;
            end
        end
    end

endmodule

// File: tb/tb_recv_module.sv
// Randomized bench for recv_module (RX_PORT=2): packets are judged whole by a rule-based model
// and compared against done/pkt_ok pulses, counters and last-header fields.
module tb_recv_module;

    localparam int RX = 2;
`ifdef RECV_DATA_CHECK_EN
    localparam bit CHECK_DATA = 1'b1;
`else
    localparam bit CHECK_DATA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ready;
    logic        rd_sop;
    logic        rd_eop;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic        done;
    logic        pkt_ok;
    logic [2:0]  last_priority;
    logic [9:0]  last_length;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    bit obs_q[$];
    bit exp_q[$];
    int m_pkt;
    int m_err;
    int m_len;
    int m_prio;
    bit pending;
    bit en_edge;
    bit ready_armed;

    recv_module #(.RX_PORT(RX), .DATA_WIDTH(32), .WIDTH_SEL(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .ready         (ready),
        .rd_sop        (rd_sop),
        .rd_eop        (rd_eop),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .done          (done),
        .pkt_ok        (pkt_ok),
        .last_priority (last_priority),
        .last_length   (last_length),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ready must equal en as it was at the previous rising edge; done pulses are collected here.
    always @(posedge clk) begin
        en_edge     = en;
        ready_armed = rst_n;
    end

    always @(negedge clk) begin
        if (rst_n && ready_armed) checkOutput("ready", {31'd0, ready}, {31'd0, en_edge});
        if (rst_n && done) obs_q.push_back(pkt_ok);
    end

    task automatic drive(input logic s, input logic v, input logic e, input logic [31:0] d);
        rd_sop  = s;
        rd_vld  = v;
        rd_eop  = e;
        rd_data = d;
        en      = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rd_sop  = 1'b0;
        rd_vld  = 1'b0;
        rd_eop  = 1'b0;
        rd_data = $urandom;
    endtask

    task automatic maybeGap();
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    endtask

    function automatic int satInc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Sends one packet; the model decides its fate from the header and framing rules.
    task automatic applyStimulus(input int dest, input int prio, input int len, input int nwords,
                                 input bit eop_last, input bit hdr_eop, input int bad_word);
        logic [31:0] hdr;
        logic [31:0] w;
        bit          closes;
        bit          good;
        if (pending) begin
            exp_q.push_back(1'b0);
            m_err = satInc(m_err);
        end
        maybeGap();
        drive(1'b1, 1'b0, 1'b0, $urandom);
        hdr = {15'($urandom), 10'(len), 3'(prio), 2'b00, 2'(dest)};
        maybeGap();
        drive(1'b0, 1'b1, hdr_eop, hdr);
        m_len  = len;
        m_prio = prio;
        if (!hdr_eop) begin
            for (int k = 0; k < nwords; k++) begin
                maybeGap();
                w = {16'(RX), 16'(k)};
                if (k == bad_word) w ^= (32'd1 << $urandom_range(0, 31));
                drive(1'b0, 1'b1, eop_last && (k == nwords - 1), w);
            end
        end
        closes = hdr_eop || (eop_last && nwords > 0);
        if (closes) begin
            good = (dest == RX) && (len != 0) && !hdr_eop && (nwords == len) &&
                   !(CHECK_DATA && bad_word >= 0 && bad_word < nwords);
            exp_q.push_back(good);
            if (good) m_pkt = satInc(m_pkt);
            else      m_err = satInc(m_err);
        end
        pending = !closes;
    endtask

    task automatic settleAndCompare();
        repeat (4) begin
            if ($urandom_range(0, 2) == 0) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom);
            else                           drive(1'b0, 1'b0, 1'b0, $urandom);
        end
        checkOutput("done_count", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            if (obs_q.size() > 0) checkOutput("pkt_ok", {31'd0, obs_q.pop_front()}, {31'd0, exp_q.pop_front()});
            else void'(exp_q.pop_front());
        end
        obs_q.delete();
        checkOutput("pkt_cnt", {16'd0, pkt_cnt}, m_pkt);
        checkOutput("err_cnt", {16'd0, err_cnt}, m_err);
        checkOutput("last_length", {22'd0, last_length}, m_len);
        checkOutput("last_priority", {29'd0, last_priority}, m_prio);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_pkt_ok"}, {31'd0, pkt_ok}, 32'd0);
        checkOutput({tag, "_prio"}, {29'd0, last_priority}, 32'd0);
        checkOutput({tag, "_len"}, {22'd0, last_length}, 32'd0);
        checkOutput({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'd0);
        checkOutput({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'd0);
    endtask

    initial begin
        int kind;
        int len;
        int dest;
        int n;
        bit eopl;
        bit he;
        int bw;
        rst_n   = 1'b0;
        en      = 1'b0;
        rd_sop  = 1'b0;
        rd_eop  = 1'b0;
        rd_vld  = 1'b0;
        rd_data = 32'd0;
        pending = 1'b0;
        m_pkt   = 0;
        m_err   = 0;
        m_len   = 0;
        m_prio  = 0;
        repeat (3) @(posedge clk);
        #1;
        checkCleared("rst");
        rst_n = 1'b1;

        applyStimulus(RX, 1, 16, 16, 1'b1, 1'b0, -1);
        settleAndCompare();
        applyStimulus(3, 2, 4, 4, 1'b1, 1'b0, -1);
        settleAndCompare();
        applyStimulus(RX, 3, 20, 12, 1'b1, 1'b0, -1);
        settleAndCompare();
        applyStimulus(RX, 4, 20, 23, 1'b1, 1'b0, -1);
        settleAndCompare();
        applyStimulus(RX, 5, 10, 5, 1'b0, 1'b0, -1);
        applyStimulus(RX, 6, 8, 8, 1'b1, 1'b0, -1);
        settleAndCompare();
        applyStimulus(RX, 7, 10, 10, 1'b1, 1'b0, 7);
        settleAndCompare();
        applyStimulus(RX, 0, 0, 3, 1'b1, 1'b0, -1);
        settleAndCompare();
        applyStimulus(RX, 2, 5, 0, 1'b0, 1'b1, -1);
        settleAndCompare();
        applyStimulus(RX, 1, 1, 1, 1'b1, 1'b0, -1);
        settleAndCompare();
        applyStimulus(RX, 6, 1023, 1023, 1'b1, 1'b0, -1);
        settleAndCompare();

        // Asynchronous reset in the middle of a packet wipes everything, nothing gets counted.
        applyStimulus(RX, 3, 12, 4, 1'b0, 1'b0, -1);
        #3;
        rst_n = 1'b0;
        #1;
        checkCleared("async");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_pkt   = 0;
        m_err   = 0;
        m_len   = 0;
        m_prio  = 0;
        pending = 1'b0;
        exp_q.delete();
        obs_q.delete();
        applyStimulus(RX, 2, 6, 6, 1'b1, 1'b0, -1);
        settleAndCompare();

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 7);
            len  = $urandom_range(2, 24);
            dest = RX;
            n    = len;
            eopl = 1'b1;
            he   = 1'b0;
            bw   = -1;
            case (kind)
                1: dest = (RX + $urandom_range(1, 3)) % 4;
                2: n = $urandom_range(1, len - 1);
                3: n = len + $urandom_range(1, 3);
                4: begin
                    len = 0;
                    n   = $urandom_range(1, 4);
                end
                5: he = 1'b1;
                6: begin
                    n    = $urandom_range(0, len - 1);
                    eopl = 1'b0;
                end
                7: bw = $urandom_range(0, len - 1);
                default: ;
            endcase
            applyStimulus(dest, $urandom_range(0, 7), len, n, eopl, he, bw);
            if (!pending) settleAndCompare();
        end
        applyStimulus(RX, 5, 9, 9, 1'b1, 1'b0, -1);
        settleAndCompare();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
